// File: rtl/mux4_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux4_arb_pkg
// Brief    : Shared types, index constants and helpers for mux4_rr_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux4_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : mux4_rr_pick
// Brief    : Combinational requester picker; round-robin after ptr, or fixed
//            lowest-index priority when MUX4_ARB_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    assign found_o = |req_i;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr_i;

    // Scan downwards so the lowest set index is the last (winning) write.
    always_comb begin
        idx_o = IDX_A;
        for (int k = 3; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_o = 2'(k);
            end
        end
    end
`else
    logic [1:0] w_cand;

    // Offsets 4..1 from ptr, scanned downwards so the nearest offset wins.
    always_comb begin
        idx_o  = IDX_A;
        w_cand = IDX_A;
        for (int k = 4; k >= 1; k--) begin
            w_cand = ptr_i + 2'(k);
            if (req_i[w_cand]) begin
                idx_o = w_cand;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mux4_rr_arbiter
// Brief    : Four-requester burst arbiter steering a 4:1 datapath mux.
//            Define MUX4_ARB_FIXED_PRIO_EN for fixed A>B>C>D priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       req_i,
    input  logic [3:0]       last_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ready_i,
    output logic [3:0]       gnt_o,
    output logic [1:0]       sel_o,
    output logic [WIDTH-1:0] out_o,
    output logic             out_valid_o,
    output logic             busy_o
);

    localparam int              CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             w_found;
    logic [1:0]       w_idx;
    logic             w_valid;
    logic             w_accept;

    mux4_rr_pick u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    assign w_valid  = (state_q == ST_GRANT) && req_i[sel_q];
    assign w_accept = w_valid && ready_i;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    gnt_d   = onehot4(w_idx);
                    sel_d   = w_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request releases without a beat; otherwise
                // LAST and the cap share one release path.
                if (!req_i[sel_q] ||
                    (w_accept && (last_i[sel_q] || (cnt_q == CNT_LAST)))) begin
                    ptr_d   = sel_q;
                    gnt_d   = 4'b0000;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= IDX_A;
            ptr_q   <= IDX_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_o = '0;
        if (w_valid) begin
            case (sel_q)
                IDX_A:   out_o = a_i;
                IDX_B:   out_o = b_i;
                IDX_C:   out_o = c_i;
                default: out_o = d_i;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign out_valid_o = w_valid;
    assign busy_o      = (state_q == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mux4_rr_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a cycle-level behavioural model (MUX4_ARB_FIXED_PRIO_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] a, b, c, d;
    logic             ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: owner is the granted requester, -1 when idle.
    int m_owner, m_sel, m_beats, m_ptr;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .last_i      (last),
        .a_i         (a),
        .b_i         (b),
        .c_i         (c),
        .d_i         (d),
        .ready_i     (ready),
        .gnt_o       (gnt),
        .sel_o       (sel),
        .out_o       (out),
        .out_valid_o (out_valid),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [WIDTH-1:0] src(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    function automatic int model_pick(input logic [3:0] r, input int p);
`ifdef MUX4_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            m_owner = -1; m_sel = 0; m_beats = 0; m_ptr = 3;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = model_pick(req, m_ptr);
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            m_ptr = m_owner; m_owner = -1;
        end else if (ready) begin
            m_beats++;
            if (last[m_owner] || m_beats == MAX_BEATS) begin
                m_ptr = m_owner; m_owner = -1;
            end
        end
    endfunction

    task automatic test_reset();
        req = 4'b1111; last = 4'b0000; ready = 1'b1;
        a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
        do_reset();
        n_vec++;
        if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_vec++;
        if (sel !== 2'b00) begin n_err++; $display("FAIL reset_sel got=%b exp=00", sel); end
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_valid_busy got=%b%b exp=00", out_valid, busy);
        end
        n_vec++;
        if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got=%h exp=0000", out); end
    endtask

    task automatic test_single_burst();
        req = 4'b0000; last = 4'b0000; ready = 1'b1;
        a = 16'h0001; b = 16'h0002; c = 16'h0003; d = 16'h0004;
        do_reset();
        rst_n = 1'b1;
        tick();
        req = 4'b0010;
        tick();
        n_vec++;
        if (gnt !== 4'b0010 || sel !== 2'b01) begin
            n_err++; $display("FAIL burst_grant got=%b/%b exp=0010/01", gnt, sel);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) last = 4'b0010;
            n_vec++;
            if (out !== 16'h0002 || !out_valid || gnt !== 4'b0010) begin
                n_err++; $display("FAIL burst_beat%0d got=%h/%b exp=0002/0010", i, out, gnt);
            end
            if (i < 2) tick();
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || out !== 16'h0000) begin
            n_err++; $display("FAIL burst_release got=%b/%h exp=0000/0000", gnt, out);
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0010) begin n_err++; $display("FAIL burst_regrant got=%b exp=0010", gnt); end
        req = 4'b0000; last = 4'b0000;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL burst_abandon got=%b/%b exp=0000/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        req = 4'b1111; last = 4'b1111; ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (gnt !== 4'(1 << (i % 4))) begin
                n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", i, gnt, 4'(1 << (i % 4)));
            end
            tick();
            n_vec++;
            if (gnt !== 4'b0000) begin n_err++; $display("FAIL rr_bubble%0d got=%b exp=0000", i, gnt); end
        end
    endtask

    task automatic test_back_pressure();
        int k;
        req = 4'b0001; last = 4'b0000; ready = 1'b1; a = 16'hA5A5;
        do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (out !== 16'hA5A5 || gnt !== 4'b0001 || sel !== 2'b00) begin
                n_err++; $display("FAIL bp_hold%0d got=%h/%b exp=a5a5/0001", i, out, gnt);
            end
        end
        ready = 1'b1;
        k = 0;
        while (gnt === 4'b0001 && k < 20) begin
            tick();
            k++;
        end
        n_vec++;
        if (k != MAX_BEATS - 2) begin
            n_err++; $display("FAIL bp_beats got=%0d exp=%0d", k + 2, MAX_BEATS);
        end
    endtask

    task automatic test_beat_cap();
        int k;
        req = 4'b0011; last = 4'b0000; ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        tick();
        k = 0;
        while (gnt === 4'b0001 && k < 20) begin
            tick();
            k++;
        end
        n_vec++;
        if (k != MAX_BEATS) begin n_err++; $display("FAIL cap_count got=%0d exp=%0d", k, MAX_BEATS); end
        n_vec++;
        if (gnt !== 4'b0000) begin n_err++; $display("FAIL cap_bubble got=%b exp=0000", gnt); end
        tick();
        n_vec++;
        if (gnt !== 4'b0010) begin n_err++; $display("FAIL cap_next got=%b exp=0010", gnt); end
    endtask

    task automatic test_reset_mid_burst();
        int exp_idx;
        req = 4'b0100; last = 4'b0000; ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b0100) begin n_err++; $display("FAIL mid_pre got=%b exp=0100", gnt); end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_abort got=%b/%b exp=0000/0", gnt, out_valid);
        end
        rst_n = 1'b1; req = 4'b1111; last = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef MUX4_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i;
`endif
            n_vec++;
            if (gnt !== 4'(1 << exp_idx)) begin
                n_err++; $display("FAIL mid_after%0d got=%b exp=%b", i, gnt, 4'(1 << exp_idx));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0]       e_gnt;
        logic [1:0]       e_sel;
        logic             e_ov, e_busy;
        logic [WIDTH-1:0] e_out;
        rst_n = 1'b0;
        model_edge();
        tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 4; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                last[i] = ($urandom_range(0, 3) == 0);
            end
            ready = ($urandom_range(0, 9) < 7);
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
            model_edge();
            tick();
            e_busy = (m_owner >= 0);
            e_gnt  = e_busy ? 4'(1 << m_owner) : 4'b0000;
            e_sel  = 2'(m_sel);
            e_ov   = e_busy && req[m_owner];
            e_out  = e_ov ? src(m_owner) : '0;
            n_vec++;
            if ({gnt, sel, out_valid, busy, out} !== {e_gnt, e_sel, e_ov, e_busy, e_out}) begin
                n_err++;
                $display("FAIL rand_cyc%0d got gnt=%b sel=%b ov=%b busy=%b out=%h exp gnt=%b sel=%b ov=%b busy=%b out=%h",
                         cyc, gnt, sel, out_valid, busy, out, e_gnt, e_sel, e_ov, e_busy, e_out);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; last = '0; ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        m_owner = -1; m_sel = 0; m_beats = 0; m_ptr = 3;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_pressure();
        test_beat_cap();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
